// File: rtl/peripheral_mpi_packet_fifo_if.sv
// Flit handshake bundle between a NoC router output, the packet FIFO and the MPI buffer input.
// The slave view belongs to the FIFO; the master view belongs to whatever drives and drains it.
interface peripheral_mpi_packet_fifo_if #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int DEPTH          = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NOC_FLIT_WIDTH-1:0] in_flit;
    logic                      in_last;
    logic                      in_valid;
    logic                      in_ready;
    logic [NOC_FLIT_WIDTH-1:0] out_flit;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [CW-1:0]             fill_level;
    logic [CW-1:0]             packet_count;

    modport slave (
        input  in_flit, in_last, in_valid, out_ready,
        output in_ready, out_flit, out_last, out_valid, fill_level, packet_count
    );

    modport master (
        output in_flit, in_last, in_valid, out_ready,
        input  in_ready, out_flit, out_last, out_valid, fill_level, packet_count
    );
endinterface

// File: rtl/peripheral_mpi_packet_fifo.sv
// Store-and-forward packet FIFO between a NoC router output and the MPI buffer NoC input.
// A packet is released only once its last flit is stored, unless it is too long to fit (cut-through fallback).
module peripheral_mpi_packet_fifo #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int DEPTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    peripheral_mpi_packet_fifo_if.slave   bus
);
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam int              AW   = $clog2(DEPTH);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [NOC_FLIT_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]           rptr, wptr;
    logic [CW-1:0]           fill_level, packet_count;
    logic                    fallback;
    logic                    full, in_ready_i, out_valid_i;
    logic                    push, pop, push_last, pop_last;
    logic [NOC_FLIT_WIDTH:0] head;

    assign full        = (fill_level == FULL);
    assign in_ready_i  = !rst && !full;
    // Fallback keeps a packet longer than DEPTH flowing once the FIFO drops below full.
    assign out_valid_i = (fill_level != '0) && ((packet_count != '0) || full || fallback);
    assign push        = bus.in_valid && in_ready_i;
    assign pop         = out_valid_i && bus.out_ready;
    assign head        = mem[rptr];
    assign push_last   = push && bus.in_last;
    assign pop_last    = pop && head[NOC_FLIT_WIDTH];

    assign bus.in_ready     = in_ready_i;
    assign bus.out_valid    = out_valid_i;
    assign bus.out_flit     = head[NOC_FLIT_WIDTH-1:0];
    assign bus.out_last     = head[NOC_FLIT_WIDTH];
    assign bus.fill_level   = fill_level;
    assign bus.packet_count = packet_count;

    // Storage is intentionally not reset; only pointers and counts qualify its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {bus.in_last, bus.in_flit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr         <= '0;
            wptr         <= '0;
            fill_level   <= '0;
            packet_count <= '0;
            fallback     <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);

            case ({push, pop})
                2'b10:   fill_level <= fill_level + CW'(1);
                2'b01:   fill_level <= fill_level - CW'(1);
                default: fill_level <= fill_level;
            endcase

            case ({push_last, pop_last})
                2'b10:   packet_count <= packet_count + CW'(1);
                2'b01:   packet_count <= packet_count - CW'(1);
                default: packet_count <= packet_count;
            endcase

            // Full with no complete packet means the head packet cannot fit; drain it through.
            if (pop_last)
                fallback <= 1'b0;
            else if (full && packet_count == '0)
                fallback <= 1'b1;
        end
    end
endmodule

// File: tb/tb_peripheral_mpi_packet_fifo.sv
// Directed and scoreboarded checks for the MPI packet FIFO (DEPTH=16, 32-bit flits).
module tb_peripheral_mpi_packet_fifo;
    localparam int W = 32;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    peripheral_mpi_packet_fifo_if #(.NOC_FLIT_WIDTH(W), .DEPTH(D)) bus ();

    peripheral_mpi_packet_fifo #(.NOC_FLIT_WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // All tasks enter and leave at a negedge with inputs settled.
    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.fill_level !== 5'd0) begin n_err++; $display("FAIL rst_fill: got %0d want 0", bus.fill_level); end
        n_cmp++; if (bus.packet_count !== 5'd0) begin n_err++; $display("FAIL rst_pkt: got %0d want 0", bus.packet_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_store_forward();
        logic [W-1:0] a [3];
        a[0] = 32'hA1; a[1] = 32'hA2; a[2] = 32'hA3;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_flit = a[i]; bus.in_last = (i == 2);
            #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sf_hold%0d: out_valid got %b want 0", i, bus.out_valid); end
            n_cmp++; if (bus.packet_count !== 5'd0) begin n_err++; $display("FAIL sf_pkt_pre%0d: got %0d want 0", i, bus.packet_count); end
            next();
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_flit !== a[i] || bus.out_last !== (i == 2))
                begin n_err++; $display("FAIL sf_pop%0d: got v=%b f=%h l=%b want v=1 f=%h l=%b", i, bus.out_valid, bus.out_flit, bus.out_last, a[i], (i == 2)); end
            n_cmp++; if (bus.packet_count !== 5'd1) begin n_err++; $display("FAIL sf_pkt_mid%0d: got %0d want 1", i, bus.packet_count); end
            next();
        end
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.packet_count !== 5'd0 || bus.fill_level !== 5'd0)
            begin n_err++; $display("FAIL sf_end: got v=%b pkt=%0d fill=%0d want 0/0/0", bus.out_valid, bus.packet_count, bus.fill_level); end
        idle();
    endtask

    task automatic test_fallback();
        int sent = 0, got = 0, cyc = 0;
        idle();
        for (int i = 0; i < D; i++) begin
            bus.in_valid = 1'b1; bus.in_flit = 32'h100 + i; bus.in_last = 1'b0;
            sent++;
            next();
        end
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.fill_level !== 5'd16) begin n_err++; $display("FAIL fb_fill: got %0d want 16", bus.fill_level); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fb_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL fb_out_valid: got %b want 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        while (got < 20 && cyc < 100) begin
            bus.in_valid = (sent < 20); bus.in_flit = 32'h100 + sent; bus.in_last = (sent == 19);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'h100 + got || bus.out_last !== (got == 19))
                begin n_err++; $display("FAIL fb_flit%0d: got v=%b f=%h l=%b want v=1 f=%h l=%b", got, bus.out_valid, bus.out_flit, bus.out_last, 32'h100 + got, (got == 19)); end
            got++;
            cyc++;
            next();
        end
        n_cmp++; if (got != 20) begin n_err++; $display("FAIL fb_timeout: got %0d flits want 20", got); end
        idle();
        #1;
        n_cmp++; if (dut.fallback !== 1'b0) begin n_err++; $display("FAIL fb_flag_clear: got %b want 0", dut.fallback); end
        n_cmp++; if (bus.fill_level !== 5'd0 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL fb_empty: got fill=%0d v=%b want 0/0", bus.fill_level, bus.out_valid); end
    endtask

    task automatic test_full();
        int got = 0, cyc = 0;
        logic [W-1:0] exp_f;
        idle();
        for (int i = 0; i < D; i++) begin
            bus.in_valid = 1'b1; bus.in_flit = 32'h200 + i; bus.in_last = 1'b1;
            next();
        end
        bus.in_flit = 32'h300; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.fill_level !== 5'd16)
            begin n_err++; $display("FAIL full_block: got rdy=%b v=%b fill=%0d want 0/1/16", bus.in_ready, bus.out_valid, bus.fill_level); end
        next(); #1;
        n_cmp++; if (bus.fill_level !== 5'd15 || bus.in_ready !== 1'b1)
            begin n_err++; $display("FAIL full_pop_only: got fill=%0d rdy=%b want 15/1", bus.fill_level, bus.in_ready); end
        n_cmp++; if (bus.packet_count !== 5'd15) begin n_err++; $display("FAIL full_pkt: got %0d want 15", bus.packet_count); end
        next(); #1;
        n_cmp++; if (bus.fill_level !== 5'd15) begin n_err++; $display("FAIL full_resume: got fill=%0d want 15", bus.fill_level); end
        bus.in_valid = 1'b0;
        while (got < 15 && cyc < 50) begin
            exp_f = (got < 14) ? 32'h202 + got : 32'h300;
            #1;
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_flit !== exp_f)
                begin n_err++; $display("FAIL full_drain%0d: got v=%b f=%h want v=1 f=%h", got, bus.out_valid, bus.out_flit, exp_f); end
            got++; cyc++;
            next();
        end
        #1;
        n_cmp++; if (bus.fill_level !== 5'd0) begin n_err++; $display("FAIL full_empty: got fill=%0d want 0", bus.fill_level); end
        idle();
    endtask

    task automatic test_simultaneous();
        idle();
        bus.in_valid = 1'b1; bus.in_flit = 32'h400; bus.in_last = 1'b1; next();
        bus.in_flit = 32'h401; next();
        bus.in_flit = 32'h402; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.packet_count !== 5'd2 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_flit !== 32'h400)
            begin n_err++; $display("FAIL sim_pre: got pkt=%0d rdy=%b v=%b f=%h want 2/1/1/400", bus.packet_count, bus.in_ready, bus.out_valid, bus.out_flit); end
        next();
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.packet_count !== 5'd2 || bus.fill_level !== 5'd2)
            begin n_err++; $display("FAIL sim_post: got pkt=%0d fill=%0d want 2/2", bus.packet_count, bus.fill_level); end
        n_cmp++; if (bus.out_flit !== 32'h401) begin n_err++; $display("FAIL sim_order1: got %h want 401", bus.out_flit); end
        next(); #1;
        n_cmp++; if (bus.out_flit !== 32'h402 || bus.out_last !== 1'b1)
            begin n_err++; $display("FAIL sim_order2: got f=%h l=%b want 402/1", bus.out_flit, bus.out_last); end
        next();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.in_valid = 1'b1; bus.in_flit = 32'h500; next();
        bus.in_flit = 32'h501; next();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.fill_level !== 5'd0 || bus.out_valid !== 1'b0 || bus.packet_count !== 5'd0 || bus.in_ready !== 1'b0)
            begin n_err++; $display("FAIL rmid_async: got fill=%0d v=%b pkt=%0d rdy=%b want 0/0/0/0", bus.fill_level, bus.out_valid, bus.packet_count, bus.in_ready); end
        next();
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_flit = 32'h600; bus.in_last = 1'b1;
        next();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_flit !== 32'h600 || bus.out_last !== 1'b1 || bus.fill_level !== 5'd1)
            begin n_err++; $display("FAIL rmid_new: got v=%b f=%h l=%b fill=%0d want 1/600/1/1", bus.out_valid, bus.out_flit, bus.out_last, bus.fill_level); end
        next(); #1;
        n_cmp++; if (bus.fill_level !== 5'd0 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL rmid_drain: got fill=%0d v=%b want 0/0", bus.fill_level, bus.out_valid); end
        idle();
    endtask

    task automatic test_random();
        logic [W:0] q[$];
        logic [W:0] exp_e;
        int sent = 0, got = 0, cyc = 0, bad = 0;
        idle();
        while (got < 10000 && cyc < 60000) begin
            bus.in_valid  = (sent < 10000) && ($urandom_range(9) < 7);
            bus.in_flit   = $urandom();
            bus.in_last   = (sent == 9999) || ($urandom_range(3) == 0);
            bus.out_ready = ($urandom_range(9) < 7);
            #1;
            n_cmp++; if (bus.fill_level !== 5'(q.size()) || bus.in_ready !== (q.size() < D))
                begin n_err++; if (bad++ < 10) $display("FAIL rnd_level: got fill=%0d rdy=%b want fill=%0d", bus.fill_level, bus.in_ready, q.size()); end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; if (bad++ < 10) $display("FAIL rnd_underflow: got pop want no pop from empty");
                end else begin
                    exp_e = q.pop_front();
                    if ({bus.out_last, bus.out_flit} !== exp_e) begin
                        n_err++; if (bad++ < 10) $display("FAIL rnd_data%0d: got %h want %h", got, {bus.out_last, bus.out_flit}, exp_e);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({bus.in_last, bus.in_flit});
                sent++;
            end
            cyc++;
            next();
        end
        n_cmp++; if (got != 10000 || q.size() != 0)
            begin n_err++; $display("FAIL rnd_complete: got %0d popped %0d left want 10000/0", got, q.size()); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        @(negedge clk);
        test_store_forward();
        test_fallback();
        test_full();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/peripheral_mpi_packet_fifo.md
PERIPHERAL_MPI_PACKET_FIFO -- requirements
Module: peripheral_mpi_packet_fifo

Interface
REQ-001 Parameters SHALL be:
- NOC_FLIT_WIDTH, default 32, flit data width.
- DEPTH, default 16, flit storage entries; power of two, at least 4.
- CW = $clog2(DEPTH+1), derived count width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_flit, input, NOC_FLIT_WIDTH, flit from NoC router.
- in_last, input, 1, marks final flit of packet.
- in_valid, input, 1, upstream flit valid.
- in_ready, output, 1, FIFO accepts flit.
- out_flit, output, NOC_FLIT_WIDTH, flit to MPI buffer noc_in_flit.
- out_last, output, 1, final-flit marker to MPI buffer.
- out_valid, output, 1, flit presented downstream.
- out_ready, input, 1, MPI buffer accepts flit.
- fill_level, output, CW, flits currently stored.
- packet_count, output, CW, complete packets (last flit stored) held.

REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-high reset (rst).

Function
REQ-004 The block SHALL sit between a NoC router output and the MPI buffer NoC input, storing flits plus last bit as {last, flit} entries in a DEPTH-entry circular buffer.
REQ-005 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-006 in_ready SHALL equal (fill_level < DEPTH) while rst is low, and 0 while rst is high.
REQ-007 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-008 fill_level SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop.
REQ-009 packet_count SHALL increment on a push with in_last=1, decrement on a pop with out_last=1, and stay unchanged when both occur in the same cycle.
REQ-010 Mode is store-and-forward: out_valid SHALL be 1 only when fill_level>0 and (packet_count>0 or fill_level==DEPTH).
REQ-011 The fill_level==DEPTH term of REQ-010 is cut-through fallback mode. It SHALL forward flits of a packet longer than DEPTH, preventing deadlock. Once entered, it SHALL stay active until the draining packet's last flit pops.
REQ-012 out_flit and out_last SHALL reflect the entry at the read pointer combinationally from storage. A flit pushed in cycle t SHALL be poppable no earlier than cycle t+1; there is no same-cycle bypass.
REQ-013 When fill_level==DEPTH, no push SHALL occur even with a simultaneous pop; in_ready is already 0.
REQ-014 out_flit/out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 A pop SHALL never occur when fill_level==0, and a push SHALL never occur when fill_level==DEPTH. Counters SHALL never underflow or overflow.
REQ-016 Packet order and flit order SHALL be preserved, with no flit duplicated or dropped.

Reset
REQ-017 On rst assertion, pointers, fill_level, packet_count and the fallback flag SHALL clear immediately (asynchronously).
REQ-018 Outputs during and after reset SHALL be: out_valid=0, in_ready=0 while rst=1, fill_level=0, packet_count=0. out_flit/out_last are don't-care and the storage array is not reset.
REQ-019 Reset asserted mid-packet SHALL discard all stored flits, including partial packets. The first accepted flit after release SHALL be treated as a packet start.
REQ-020 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-021 Directed scenarios:
- 3-flit packet A1,A2,A3(last) pushed on consecutive cycles, out_ready=1 -> out_valid stays 0 until the cycle after A3 is pushed, then A1,A2,A3 on three consecutive cycles; packet_count sequence 0,1,0.
- DEPTH=16, 20-flit packet, out_ready=0 until fill_level=16 -> in_ready=0 and out_valid=1 at fill_level 16. Then out_ready=1 -> all 20 flits delivered in order; fallback flag clears after flit 20 pops.
- Full FIFO (16 one-flit packets), in_valid=1 and out_ready=1 -> a pop occurs but no push that cycle; fill_level goes 16->15, and a push resumes next cycle.
- Simultaneous push of a last flit and pop of a last flit with packet_count=2 -> packet_count stays 2 and fill_level unchanged.
- Reset pulsed after 2 flits of an unfinished packet -> fill_level=0, out_valid=0 immediately. A new 1-flit packet is delivered correctly afterwards.
- Random in_valid/out_ready over 10,000 flits, wrap-around exercised -> scoreboard shows no loss, duplication or reorder, and last bits intact.
